// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte FIFOs.
// Pops one byte per frame, strobes it into the shifter and waits for idle to return.
module uart_tx_arbiter #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned TIMEOUT = 100000,
    parameter int unsigned CNT_W   = 17
) (
    input  logic              clock_system,
    input  logic              rstn,
    input  logic              empty0,
    input  logic [DATA_W-1:0] dout0,
    output logic              rd_en0,
    input  logic              empty1,
    input  logic [DATA_W-1:0] dout1,
    output logic              rd_en1,
    input  logic [1:0]        ch_en,
    input  logic              idle,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    output logic              tx_ch,
    output logic              timeout_err
);

    localparam int unsigned LAT_W   = 2;
    localparam int unsigned HOLD_W  = 2;
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_RD    = 6'b000010,
        S_LAT   = 6'b000100,
        S_START = 6'b001000,
        S_SEND  = 6'b010000,
        S_HOLD  = 6'b100000
    } state_t;

    state_t state, state_nx;

    logic empty0_m, empty0_s, empty1_m, empty1_s;
    logic idle_m, idle_s, idle_s_prev;
    logic idle_rise;
    logic [1:0] req;
    logic grant;

    logic [LAT_W-1:0]  lat_cnt, lat_cnt_nx;
    logic [CNT_W-1:0]  to_cnt, to_cnt_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;
    logic              last_grant, last_grant_nx;

    logic              rd_en0_nx, rd_en1_nx, tx_start_nx, tx_ch_nx, timeout_err_nx;
    logic [DATA_W-1:0] tx_data_nx;

    // Two-flop synchronisers; idle gets a third flop for edge detection
    always_ff @(posedge clock_system or negedge rstn) begin
        if (!rstn) begin
            empty0_m    <= 1'b1;
            empty0_s    <= 1'b1;
            empty1_m    <= 1'b1;
            empty1_s    <= 1'b1;
            idle_m      <= 1'b1;
            idle_s      <= 1'b1;
            idle_s_prev <= 1'b1;
        end else begin
            empty0_m    <= empty0;
            empty0_s    <= empty0_m;
            empty1_m    <= empty1;
            empty1_s    <= empty1_m;
            idle_m      <= idle;
            idle_s      <= idle_m;
            idle_s_prev <= idle_s;
        end
    end

    assign idle_rise = idle_s & ~idle_s_prev;
    assign req       = ~{empty1_s, empty0_s} & ch_en;
    // On contention the channel that did not win last time goes next
    assign grant     = (req == 2'b11) ? ~last_grant : ~req[0];

    always_ff @(posedge clock_system or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            lat_cnt     <= '0;
            to_cnt      <= '0;
            hold_cnt    <= '0;
            last_grant  <= 1'b1;
            rd_en0      <= 1'b0;
            rd_en1      <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            tx_ch       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            lat_cnt     <= lat_cnt_nx;
            to_cnt      <= to_cnt_nx;
            hold_cnt    <= hold_cnt_nx;
            last_grant  <= last_grant_nx;
            rd_en0      <= rd_en0_nx;
            rd_en1      <= rd_en1_nx;
            tx_start    <= tx_start_nx;
            tx_data     <= tx_data_nx;
            tx_ch       <= tx_ch_nx;
            timeout_err <= timeout_err_nx;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_nx       = state;
        lat_cnt_nx     = lat_cnt;
        to_cnt_nx      = to_cnt;
        hold_cnt_nx    = hold_cnt;
        last_grant_nx  = last_grant;
        rd_en0_nx      = 1'b0;
        rd_en1_nx      = 1'b0;
        tx_start_nx    = 1'b0;
        timeout_err_nx = 1'b0;
        tx_data_nx     = tx_data;
        tx_ch_nx       = tx_ch;

        case (state)
            S_IDLE: begin
                if (idle_s && (req != 2'b00)) begin
                    state_nx      = S_RD;
                    tx_ch_nx      = grant;
                    last_grant_nx = grant;
                    rd_en0_nx     = ~grant;
                    rd_en1_nx     = grant;
                end
            end
            S_RD: begin
                state_nx   = S_LAT;
                lat_cnt_nx = LAT_W'(RD_LAT - 1);
            end
            S_LAT: begin
                if (lat_cnt == '0) begin
                    state_nx    = S_START;
                    tx_data_nx  = tx_ch ? dout1 : dout0;
                    tx_start_nx = 1'b1;
                end else begin
                    lat_cnt_nx = lat_cnt - LAT_W'(1);
                end
            end
            S_START: begin
                state_nx  = S_SEND;
                to_cnt_nx = '0;
            end
            S_SEND: begin
                if (idle_rise) begin
                    state_nx    = S_HOLD;
                    hold_cnt_nx = '0;
                end else if ((TIMEOUT != 0) && (to_cnt == CNT_W'(TO_LAST))) begin
                    state_nx       = S_HOLD;
                    hold_cnt_nx    = '0;
                    timeout_err_nx = 1'b1;
                end else begin
                    to_cnt_nx = to_cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                // Gives the empty synchronisers time to see the pop
                if (hold_cnt == HOLD_W'(2)) begin
                    state_nx = S_IDLE;
                end else begin
                    hold_cnt_nx = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: timeline model of the arbitration protocol, per-cycle compare,
// plus literal expectations on grant order, latencies and timeouts.
module tb_uart_tx_arbiter;

    localparam int P_RD_LAT  = 3;
    localparam int P_TIMEOUT = 60;
    localparam int BUSY      = 50;

    localparam int M_AVAIL = 0;
    localparam int M_XFER  = 1;
    localparam int M_WAIT  = 2;
    localparam int M_HOLD  = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // Main instance: RD_LAT=3, TIMEOUT=60
    logic       empty0 = 1'b1, empty1 = 1'b1;
    logic [7:0] dout0, dout1;
    logic       rd_en0, rd_en1;
    logic [1:0] ch_en = 2'b11;
    logic       idle = 1'b1;
    logic [7:0] tx_data;
    logic       tx_start, tx_ch, timeout_err;

    uart_tx_arbiter #(.DATA_W(8), .RD_LAT(P_RD_LAT), .TIMEOUT(P_TIMEOUT), .CNT_W(17)) u_dut (
        .clock_system(clk), .rstn(rstn),
        .empty0(empty0), .dout0(dout0), .rd_en0(rd_en0),
        .empty1(empty1), .dout1(dout1), .rd_en1(rd_en1),
        .ch_en(ch_en), .idle(idle),
        .tx_data(tx_data), .tx_start(tx_start), .tx_ch(tx_ch), .timeout_err(timeout_err)
    );

    // Second instance with default parameters for the RD_LAT=1 latency check
    logic       b_has = 1'b0;
    logic       b_empty0;
    logic [7:0] b_dout0 = 8'h00;
    logic [7:0] b_dout1 = 8'h3C;
    logic       b_rd_en0, b_rd_en1, b_tx_start, b_tx_ch, b_timeout_err;
    logic [7:0] b_tx_data;
    assign b_empty0 = ~b_has;

    uart_tx_arbiter u_dut_b (
        .clock_system(clk), .rstn(rstn),
        .empty0(b_empty0), .dout0(b_dout0), .rd_en0(b_rd_en0),
        .empty1(1'b1), .dout1(b_dout1), .rd_en1(b_rd_en1),
        .ch_en(2'b11), .idle(1'b1),
        .tx_data(b_tx_data), .tx_start(b_tx_start), .tx_ch(b_tx_ch), .timeout_err(b_timeout_err)
    );

    always @(posedge clk) b_dout0 <= b_rd_en0 ? 8'hA5 : 8'h00;

    // FIFO models: main owns write pointers, this block owns read pointers
    logic [7:0] mem0 [32];
    logic [7:0] mem1 [32];
    int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0, uf = 0;
    logic [7:0] p0 [P_RD_LAT];
    logic [7:0] p1 [P_RD_LAT];
    assign dout0 = p0[P_RD_LAT-1];
    assign dout1 = p1[P_RD_LAT-1];

    always @(posedge clk) begin
        for (int k = P_RD_LAT - 1; k > 0; k--) begin
            p0[k] <= p0[k-1];
            p1[k] <= p1[k-1];
        end
        p0[0] <= 8'hEE;
        p1[0] <= 8'hEE;
        if (rd_en0) begin
            if (rp0 == wp0) uf++;
            else begin p0[0] <= mem0[rp0]; rp0++; end
        end
        if (rd_en1) begin
            if (rp1 == wp1) uf++;
            else begin p1[0] <= mem1[rp1]; rp1++; end
        end
        empty0 <= (rp0 == wp0);
        empty1 <= (rp1 == wp1);
    end

    // Transmitter model: idle drops one clock after tx_start for BUSY clocks
    logic hang = 1'b0, force_busy = 1'b0, hung = 1'b0;
    int   tcnt = 0;
    always @(negedge clk) begin
        if (tx_start && !hang) tcnt = BUSY + 1;
        else if (tcnt != 0) tcnt = tcnt - 1;
        hung = hang && (hung || tx_start);
        idle = !(tcnt != 0 && tcnt <= BUSY) && !hung && !force_busy;
    end

    // Behavioural model: a transfer is a timeline of read, fixed latency, wait for idle, hold
    logic       exp_rd0, exp_rd1, exp_start, exp_to, exp_ch;
    logic [7:0] exp_data, m_byte;
    logic [1:0] e_m, e_s, m_req;
    logic       i_m, i_s, i_p, m_last, m_g, m_rise;
    int         m_mode, m_n, mp0 = 0, mp1 = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_mode = M_AVAIL; m_n = 0; m_last = 1'b1;
            e_m = 2'b11; e_s = 2'b11; i_m = 1'b1; i_s = 1'b1; i_p = 1'b1;
            exp_rd0 = 1'b0; exp_rd1 = 1'b0; exp_start = 1'b0; exp_to = 1'b0;
            exp_ch = 1'b0; exp_data = 8'h00;
        end else begin
            m_rise = i_s && !i_p;
            m_req  = ~e_s & ch_en;
            exp_rd0 = 1'b0; exp_rd1 = 1'b0; exp_start = 1'b0; exp_to = 1'b0;
            case (m_mode)
                M_AVAIL: if (i_s && m_req != 2'b00) begin
                    if (m_req == 2'b11) m_g = !m_last;
                    else                m_g = m_req[1];
                    m_last = m_g;
                    exp_ch = m_g;
                    if (m_g) begin exp_rd1 = 1'b1; m_byte = mem1[mp1]; mp1++; end
                    else     begin exp_rd0 = 1'b1; m_byte = mem0[mp0]; mp0++; end
                    m_mode = M_XFER; m_n = 0;
                end
                M_XFER: begin
                    m_n++;
                    if (m_n == P_RD_LAT + 1) begin
                        exp_start = 1'b1; exp_data = m_byte; m_mode = M_WAIT; m_n = 0;
                    end
                end
                M_WAIT: begin
                    m_n++;
                    if (m_n >= 2) begin
                        if (m_rise) begin m_mode = M_HOLD; m_n = 0; end
                        else if (P_TIMEOUT != 0 && m_n - 1 == P_TIMEOUT) begin
                            exp_to = 1'b1; m_mode = M_HOLD; m_n = 0;
                        end
                    end
                end
                default: begin
                    m_n++;
                    if (m_n == 3) m_mode = M_AVAIL;
                end
            endcase
            i_p = i_s; i_s = i_m; i_m = idle;
            e_s = e_m; e_m = {empty1, empty0};
        end
    end

    int vec = 0, miss = 0, cyc = 0, rd0_n = 0, rd1_n = 0, to_t = -1;
    int rd_t [$];
    int st_t [$];
    logic       st_ch   [$];
    logic [7:0] st_data [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rstn) begin
            check("rd_en0", 32'(rd_en0), 32'(exp_rd0));
            check("rd_en1", 32'(rd_en1), 32'(exp_rd1));
            check("tx_start", 32'(tx_start), 32'(exp_start));
            check("tx_data", 32'(tx_data), 32'(exp_data));
            check("tx_ch", 32'(tx_ch), 32'(exp_ch));
            check("timeout_err", 32'(timeout_err), 32'(exp_to));
        end
        if (rd_en0) rd0_n++;
        if (rd_en1) rd1_n++;
        if (rd_en0 || rd_en1) rd_t.push_back(cyc);
        if (tx_start) begin st_t.push_back(cyc); st_ch.push_back(tx_ch); st_data.push_back(tx_data); end
        if (timeout_err) to_t = cyc;
    endtask

    task automatic load0(input logic [7:0] v); mem0[wp0] = v; wp0++; endtask
    task automatic load1(input logic [7:0] v); mem1[wp1] = v; wp1++; endtask

    task automatic wait_starts(input int n, input int budget);
        int b = 0;
        while (st_t.size() < n && b < budget) begin tick(); b++; end
        check("start_count", 32'(st_t.size()), 32'(n));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_rd_en0"}, 32'(rd_en0), 32'd0);
        check({tag, "_rd_en1"}, 32'(rd_en1), 32'd0);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_tx_ch"}, 32'(tx_ch), 32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    logic       exp_ch_l   [16];
    logic [7:0] exp_data_l [16];

    initial begin
        int b_rd0, b_rd1, b_rd_t, b_st_t, base, load_t, rd_before, b;
        logic [7:0] b_data;
        logic       b_ch;
        exp_ch_l   = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1};
        exp_data_l = '{8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23, 8'h5A, 8'h77,
                       8'h88, 8'hC1, 8'h41, 8'h31, 8'h42, 8'h32, 8'h99, 8'h9B};

        run(3);
        check_reset_outs("reset");
        rstn = 1'b1;
        run(4);

        // Single byte on FIFO0, RD_LAT=1 instance
        b_rd0 = 0; b_rd1 = 0; b_rd_t = -1; b_st_t = -1; b_data = 8'h00; b_ch = 1'b1;
        b_has = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (b_rd_en0) begin b_rd0++; b_rd_t = t; b_has = 1'b0; end
            if (b_rd_en1) b_rd1++;
            if (b_tx_start) begin b_st_t = t; b_data = b_tx_data; b_ch = b_tx_ch; end
        end
        check("b_rd_latency", 32'(b_rd_t), 32'd3);
        check("b_start_latency", 32'(b_st_t), 32'd5);
        check("b_tx_data", 32'(b_data), 32'hA5);
        check("b_tx_ch", 32'(b_ch), 32'd0);
        check("b_rd_en0_count", 32'(b_rd0), 32'd1);
        check("b_rd_en1_count", 32'(b_rd1), 32'd0);

        // Three bytes on each FIFO: strict alternation
        load_t = cyc;
        load0(8'h11); load0(8'h12); load0(8'h13);
        load1(8'h21); load1(8'h22); load1(8'h23);
        wait_starts(6, 1500);
        if (rd_t.size() > 0 && st_t.size() > 0) begin
            check("rd_latency", 32'(rd_t[0] - load_t), 32'd4);
            check("rd_to_start", 32'(st_t[0] - rd_t[0]), 32'(P_RD_LAT + 1));
        end else check("first_transfer_seen", 32'(rd_t.size()), 32'd1);
        run(80);

        // Single byte: no second read across HOLD to IDLE
        base = rd0_n; rd_before = rd1_n;
        load0(8'h5A);
        wait_starts(7, 300);
        run(100);
        check("single_rd0", 32'(rd0_n - base), 32'd1);
        check("single_rd1", 32'(rd1_n - rd_before), 32'd0);

        // Timeout with the transmitter stuck busy, then recovery
        hang = 1'b1;
        load1(8'h77);
        wait_starts(8, 300);
        b = 0;
        while (to_t < 0 && b < 200) begin tick(); b++; end
        if (st_t.size() >= 8) check("timeout_delay", 32'(to_t - st_t[7]), 32'(P_TIMEOUT + 1));
        hang = 1'b0;
        load0(8'h88);
        wait_starts(9, 300);
        run(80);

        // Transmitter busy while IDLE: no read until it frees up
        force_busy = 1'b1;
        base = rd0_n;
        load0(8'hC1);
        run(40);
        check("busy_no_read", 32'(rd0_n - base), 32'd0);
        force_busy = 1'b0;
        wait_starts(10, 100);
        run(80);

        // Channel 0 masked, then unmasked mid-SEND
        ch_en = 2'b10;
        load0(8'h31); load0(8'h32);
        load1(8'h41); load1(8'h42);
        wait_starts(11, 300);
        run(2);
        ch_en = 2'b11;
        wait_starts(14, 800);
        run(80);

        // Reset during LAT; popped byte is lost, channel 0 wins after release
        load0(8'h99); load1(8'h9A);
        base = rd_t.size();
        b = 0;
        while (rd_t.size() == base && b < 50) begin tick(); b++; end
        check("pre_reset_read", 32'(rd_t.size() - base), 32'd1);
        tick();
        rstn = 1'b0;
        #1;
        check_reset_outs("midreset");
        load1(8'h9B);
        run(3);
        rstn = 1'b1;
        wait_starts(16, 600);
        run(80);

        check("log_len", 32'(st_ch.size()), 32'd16);
        for (int i = 0; i < 16 && i < st_ch.size(); i++) begin
            check($sformatf("grant_%0d", i), 32'(st_ch[i]), 32'(exp_ch_l[i]));
            check($sformatf("data_%0d", i), 32'(st_data[i]), 32'(exp_data_l[i]));
        end
        check("underflow", 32'(uf), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between two byte FIFOs (channel 0 and channel 1).
- Arbitration is round-robin.
- For each byte: pops one byte from the granted FIFO, presents it to the transmitter with a one-cycle start strobe, then waits for the transmitter to return idle.
- Sits between the TX FIFOs and the UART TX shifter. It replaces single-FIFO read sequencing when a second source, such as a debug or status stream, shares the serial line.

Parameters:
- DATA_W, 8: byte width of the FIFO read data and tx_data.
- RD_LAT, 1: FIFO read latency in clocks, from rd_en high to dout valid. Legal values 1..3.
- TIMEOUT, 100000: clocks allowed in SEND before abort. 0 disables the timeout.
- CNT_W, 17: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock_system  in  1  system clock; all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- empty0  in  1  FIFO 0 empty flag (may be asynchronous)
- dout0  in  DATA_W  FIFO 0 read data
- rd_en0  out  1  FIFO 0 read strobe
- empty1  in  1  FIFO 1 empty flag (may be asynchronous)
- dout1  in  DATA_W  FIFO 1 read data
- rd_en1  out  1  FIFO 1 read strobe
- ch_en  in  2  per-channel enable mask; bit i=0 excludes channel i from arbitration
- idle  in  1  transmitter idle, high when the shifter is not sending
- tx_data  out  DATA_W  byte to transmit
- tx_start  out  1  one-cycle load strobe to the transmitter
- tx_ch  out  1  channel that owns the current byte
- timeout_err  out  1  one-cycle pulse when SEND aborts on timeout

Behaviour:
- Synchronisers:
  - empty0, empty1 and idle each pass through a 2-flop synchroniser (empty*_s, idle_s).
  - Reset values: empty*_s = 1, idle_s = 1.
  - idle_rise = idle_s & ~idle_s_prev (third flop). idle_rise is used only in SEND.
- Outputs:
  - All outputs are registered, with no combinational path from any input.
  - Reset values: rd_en0/1 = 0, tx_start = 0, tx_data = 0, tx_ch = 0, timeout_err = 0.
- Request and grant:
  - req[i] = ~empty_i_s & ch_en[i].
  - Grant goes to the requesting channel. If both request, grant goes to the channel != last_grant.
  - last_grant resets to 1, so channel 0 wins the first contention.
  - last_grant updates on entry to RD.
- FSM states (one-hot, 6 states): IDLE, RD, LAT, START, SEND, HOLD. Reset state is IDLE.
  - IDLE: if idle_s=1 and req != 0, go to RD and latch the granted channel into tx_ch. Otherwise stay.
  - RD: rd_en of the granted channel is high for exactly this one cycle. Next state is LAT. The lat counter loads RD_LAT-1.
  - LAT: count down the lat counter. On the cycle it reaches 0, capture dout[tx_ch] into tx_data and go to START. With RD_LAT=1, LAT lasts one cycle.
  - START: tx_start = 1 for this one cycle; tx_data is stable. Next state is SEND. The timeout counter clears.
  - SEND: wait for idle_rise, then go to HOLD.
    - If TIMEOUT != 0 and the counter reaches TIMEOUT first: pulse timeout_err for one cycle and go to HOLD.
    - idle_rise in any state other than SEND is ignored.
  - HOLD: lasts 3 cycles, then returns to IDLE. This lets empty*_s reflect the FIFO state after the pop, so a stale empty flag can never cause an underflow read.
- Hold rules:
  - tx_data and tx_ch hold their values until the next capture.
  - ch_en changes take effect only at the IDLE decision. A transfer already granted always completes.
- Latency:
  - From empty falling to rd_en high: 3 clocks (2 sync + 1 decision), provided the FSM is in IDLE with idle_s=1.
  - From rd_en to tx_start: RD_LAT+1 clocks.
- Throughput: at most one byte per transmitter frame.
- Boundary conditions:
  - Both FIFOs empty, or ch_en = 0: the FSM stays in IDLE and no strobes are issued.
  - idle is low in IDLE (transmitter busy from another cause): no read is issued.
  - A channel's request disappears while the other's is pending: the next grant goes to whichever channel still requests.
  - Reset asserted mid-transfer: the FSM returns to IDLE immediately and all outputs take reset values. A byte already popped is discarded; this loss is accepted.

Test Plan:
- Reset, then only FIFO0 holding 0xA5, idle=1 -> rd_en0 pulses once, 3 clocks after empty0 falls. tx_start follows 2 clocks later (RD_LAT=1) with tx_data=0xA5, tx_ch=0. rd_en1 never asserts.
- Both FIFOs hold 3 bytes each, idle drops 1 clock after tx_start and rises 50 clocks later -> grant order 0,1,0,1,0,1; exactly 6 tx_start pulses; no rd_en on an empty FIFO.
- FIFO0 holds 1 byte -> after the pop, empty0 rises. Check that no second rd_en0 occurs across the HOLD to IDLE transition.
- TIMEOUT=20, idle held low after tx_start -> timeout_err pulses at 20 clocks in SEND; after HOLD the FSM accepts the next request.
- ch_en=2'b10, both FIFOs non-empty -> only rd_en1 ever pulses. Then set ch_en=2'b11 mid-SEND -> the next grant is channel 0.
- rstn pulsed low during LAT with RD_LAT=3 -> all outputs are 0 within the same cycle. After release, the FSM restarts from IDLE with channel 0 first.
